// File: rtl/gpu_fio_top.sv
// rtl/gpu_fio_top.sv - compact 8-lane SIMT GPU core with FileIO-loaded storage and task manager
//
// Purpose: single-warp-at-a-time SIMT core. A task-manager FIFO holds warp
// descriptors; while start is high, the idle core pops one, runs it from the
// instruction BRAM until EXIT, then pops the next. Instruction, data and
// CLE latency storage are loaded and dumped by the host through FIO ports.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   Wen/Din_FIO_TM            descriptor push {pc[28:19], mask[18:11], warp_id[10:8], rsvd[7:0]}
//   start/clear_FIO_TM        launch enable (level) / FIFO flush + finished clear
//   finished_TM_FIO           sticky: started, FIFO empty, core idle
//   *_FIO_ICache              instruction BRAM host port, 1-cycle registered read
//   *_FIO_MEM                 256-bit row host port (global + shared), 1-cycle registered read
//   *_FIO_CLE                 per-global-row extra miss latency table write port
module gpu_fio_top #(
  parameter int MEM_SIZE   = 256,
  parameter int SHMEM_SIZE = 256,
  parameter int CACHE_SIZE = 64,
  parameter int TM_DEPTH   = 8,
  parameter int AW         = $clog2(MEM_SIZE + SHMEM_SIZE),
  parameter int CW         = $clog2(MEM_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Wen_FIO_TM,
  input  logic [28:0]   Din_FIO_TM,
  input  logic          start_FIO_TM,
  input  logic          clear_FIO_TM,
  output logic          finished_TM_FIO,
  input  logic          Wen_FIO_ICache,
  input  logic [9:0]    Addr_FIO_ICache,
  input  logic [31:0]   Din_FIO_ICache,
  output logic [31:0]   Dout_FIO_ICache,
  input  logic          Wen_FIO_MEM,
  input  logic [AW-1:0] Addr_FIO_MEM,
  input  logic [255:0]  Din_FIO_MEM,
  output logic [255:0]  Dout_FIO_MEM,
  input  logic          Wen_FIO_CLE,
  input  logic [4:0]    Din_FIO_CLE,
  input  logic [CW-1:0] Addr_FIO_CLE
);

  localparam int ROWS = MEM_SIZE + SHMEM_SIZE;
  localparam int PW   = $clog2(TM_DEPTH);

  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_TID  = 4'h6;
  localparam logic [3:0] OP_BLT  = 4'h7;
  localparam logic [3:0] OP_EXIT = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_MEMWAIT} state_e;

  // Storage without reset: contents survive rst
  logic [31:0]  imem [1024];
  logic [255:0] dmem [ROWS];
  logic [4:0]   cle  [MEM_SIZE];

  // Core and task-manager state
  state_e        state_q;
  logic [9:0]    pc_q;
  logic [7:0]    mask_q;
  logic [2:0]    warp_q;
  logic [31:0]   instr_q;
  logic [AW-1:0] row_q;
  logic [4:0]    wait_q;
  logic [31:0]   regs_q [8][8];   // [lane][register]
  logic [20:0]   fifo_q [TM_DEPTH]; // {pc, mask, warp_id}
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q;
  logic          finished_q;
  logic [31:0]   dout_ic_q;
  logic [255:0]  dout_mem_q;

  assign finished_TM_FIO = finished_q;
  assign Dout_FIO_ICache = dout_ic_q;
  assign Dout_FIO_MEM    = dout_mem_q;

  // Decode
  logic [3:0]  op;
  logic [2:0]  rd, rs, rt;
  logic [15:0] imm;
  logic [31:0] imm_sx;
  assign op     = instr_q[31:28];
  assign rd     = instr_q[27:25];
  assign rs     = instr_q[24:22];
  assign rt     = instr_q[21:19];
  assign imm    = instr_q[15:0];
  assign imm_sx = {{16{imm[15]}}, imm};

  logic unused_bits;
  assign unused_bits = ^{instr_q[18:16], Din_FIO_TM[7:0]};

  // Lowest active lane drives branch compares and LD/ST row selection;
  // with an empty mask lane 0 is used so the warp still runs to EXIT.
  logic [2:0] lead;
  always_comb begin
    lead = 3'd0;
    for (int l = 7; l >= 0; l--) begin
      if (mask_q[l]) lead = 3'(l);
    end
  end

  logic [31:0] rs_val  [8];
  logic [31:0] rt_val  [8];
  logic [31:0] alu_res [8];
  always_comb begin
    for (int l = 0; l < 8; l++) begin
      rs_val[l] = (rs == 3'd0) ? 32'd0 : regs_q[l][rs];
      rt_val[l] = (rt == 3'd0) ? 32'd0 : regs_q[l][rt];
      case (op)
        OP_ADDI: alu_res[l] = rs_val[l] + imm_sx;
        OP_ADD:  alu_res[l] = rs_val[l] + rt_val[l];
        OP_MUL:  alu_res[l] = rs_val[l] * rt_val[l];
        OP_TID:  alu_res[l] = {26'd0, warp_q, 3'(l)};
        default: alu_res[l] = 32'd0;
      endcase
    end
  end

  logic        writes_rd;
  assign writes_rd = (op == OP_ADDI) || (op == OP_ADD) || (op == OP_MUL) || (op == OP_TID);

  logic [31:0]   lead_rs, lead_rt, mem_sum, row_full;
  logic [AW-1:0] row_d;
  logic          row_miss, blt_take;
  logic [4:0]    cle_rd;
  assign lead_rs  = rs_val[lead];
  assign lead_rt  = rt_val[lead];
  assign mem_sum  = lead_rs + imm_sx;
  assign row_full = mem_sum % 32'(ROWS);
  assign row_d    = row_full[AW-1:0];
  // Only global rows at or above the cached window pay the CLE penalty
  assign row_miss = (row_full < 32'(MEM_SIZE)) && (row_full >= 32'(CACHE_SIZE));
  assign cle_rd   = cle[row_d[CW-1:0]];
  assign blt_take = $signed(lead_rs) < $signed(lead_rt);

  logic [255:0] ld_row;
  logic         core_we;
  assign ld_row  = dmem[row_q];
  assign core_we = (state_q == S_MEMWAIT) && (wait_q == 5'd0) && (op == OP_ST);

  logic fifo_full, fifo_empty, tm_push, tm_pop;
  assign fifo_full  = (cnt_q == (PW+1)'(TM_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign tm_push    = Wen_FIO_TM && !fifo_full && !clear_FIO_TM;
  assign tm_pop     = (state_q == S_IDLE) && start_FIO_TM && !fifo_empty && !clear_FIO_TM;

  // Host-side storage writes. The core store is issued after the FIO write so
  // that, on a same-row collision, the lanes the core stores take its data.
  always_ff @(posedge clk) begin
    if (Wen_FIO_ICache) imem[Addr_FIO_ICache] <= Din_FIO_ICache;
  end

  always_ff @(posedge clk) begin
    if (Wen_FIO_CLE) cle[Addr_FIO_CLE] <= Din_FIO_CLE;
  end

  always_ff @(posedge clk) begin
    if (Wen_FIO_MEM) dmem[Addr_FIO_MEM] <= Din_FIO_MEM;
    if (core_we) begin
      for (int l = 0; l < 8; l++) begin
        if (mask_q[l]) dmem[row_q][32*l +: 32] <= rt_val[l];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      mask_q     <= '0;
      warp_q     <= '0;
      instr_q    <= '0;
      row_q      <= '0;
      wait_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      finished_q <= 1'b0;
      dout_ic_q  <= '0;
      dout_mem_q <= '0;
      for (int l = 0; l < 8; l++) begin
        for (int r = 0; r < 8; r++) regs_q[l][r] <= '0;
      end
      for (int i = 0; i < TM_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      dout_ic_q  <= imem[Addr_FIO_ICache];
      dout_mem_q <= dmem[Addr_FIO_MEM];

      // Task-manager FIFO; clear wins over any push/pop in the same cycle
      if (clear_FIO_TM) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (tm_push) begin
          fifo_q[wr_ptr_q] <= Din_FIO_TM[28:8];
          wr_ptr_q         <= wr_ptr_q + 1'b1;
        end
        if (tm_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({tm_push, tm_pop})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: cnt_q <= cnt_q;
        endcase
      end

      if (clear_FIO_TM) begin
        finished_q <= 1'b0;
      end else if (start_FIO_TM && fifo_empty && (state_q == S_IDLE)) begin
        finished_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (tm_pop) begin
            {pc_q, mask_q, warp_q} <= fifo_q[rd_ptr_q];
            for (int l = 0; l < 8; l++) begin
              for (int r = 0; r < 8; r++) regs_q[l][r] <= '0;
            end
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          instr_q <= imem[pc_q];
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          pc_q    <= pc_q + 10'd1;
          state_q <= S_FETCH;
          if (writes_rd && (rd != 3'd0)) begin
            for (int l = 0; l < 8; l++) begin
              if (mask_q[l]) regs_q[l][rd] <= alu_res[l];
            end
          end
          case (op)
            OP_LD, OP_ST: begin
              row_q   <= row_d;
              wait_q  <= row_miss ? cle_rd : 5'd0;
              state_q <= S_MEMWAIT;
            end
            OP_BLT: begin
              if (blt_take) pc_q <= pc_q + imm_sx[9:0];
            end
            OP_EXIT: begin
              state_q <= S_IDLE;
            end
            default: ;
          endcase
        end
        S_MEMWAIT: begin
          // The access completes in the cycle the countdown reaches zero
          if (wait_q != 5'd0) begin
            wait_q <= wait_q - 5'd1;
          end else begin
            if ((op == OP_LD) && (rd != 3'd0)) begin
              for (int l = 0; l < 8; l++) begin
                if (mask_q[l]) regs_q[l][rd] <= ld_row[32*l +: 32];
              end
            end
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_fio_top.sv
// tb/tb_gpu_fio_top.sv - self-checking bench for gpu_fio_top
module tb_gpu_fio_top;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         Wen_FIO_TM = 1'b0;
  logic [28:0]  Din_FIO_TM = '0;
  logic         start_FIO_TM = 1'b0;
  logic         clear_FIO_TM = 1'b0;
  logic         finished_TM_FIO;
  logic         Wen_FIO_ICache = 1'b0;
  logic [9:0]   Addr_FIO_ICache = '0;
  logic [31:0]  Din_FIO_ICache = '0;
  logic [31:0]  Dout_FIO_ICache;
  logic         Wen_FIO_MEM = 1'b0;
  logic [8:0]   Addr_FIO_MEM = '0;
  logic [255:0] Din_FIO_MEM = '0;
  logic [255:0] Dout_FIO_MEM;
  logic         Wen_FIO_CLE = 1'b0;
  logic [4:0]   Din_FIO_CLE = '0;
  logic [7:0]   Addr_FIO_CLE = '0;

  always #5 clk = ~clk;

  gpu_fio_top dut (
    .clk(clk), .rst(rst),
    .Wen_FIO_TM(Wen_FIO_TM), .Din_FIO_TM(Din_FIO_TM),
    .start_FIO_TM(start_FIO_TM), .clear_FIO_TM(clear_FIO_TM),
    .finished_TM_FIO(finished_TM_FIO),
    .Wen_FIO_ICache(Wen_FIO_ICache), .Addr_FIO_ICache(Addr_FIO_ICache),
    .Din_FIO_ICache(Din_FIO_ICache), .Dout_FIO_ICache(Dout_FIO_ICache),
    .Wen_FIO_MEM(Wen_FIO_MEM), .Addr_FIO_MEM(Addr_FIO_MEM),
    .Din_FIO_MEM(Din_FIO_MEM), .Dout_FIO_MEM(Dout_FIO_MEM),
    .Wen_FIO_CLE(Wen_FIO_CLE), .Din_FIO_CLE(Din_FIO_CLE), .Addr_FIO_CLE(Addr_FIO_CLE)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [8:0]   row;
    logic [255:0] data;
  } memvec_t;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] instr;
  } prog_t;

  typedef struct {
    logic [9:0]   pc;
    logic [7:0]   mask;
    logic [2:0]   warp;
    logic         pre;
    logic [255:0] pre_d;
    logic [8:0]   row;
    logic [255:0] exp;
  } warpvec_t;

  memvec_t  mvec [4];
  prog_t    prog [26];
  warpvec_t wvec [5];
  logic [255:0] sb_q [$];

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [2:0] rt,
                                      input logic [15:0] imm);
    return {op, rd, rs, rt, 3'b000, imm};
  endfunction

  function automatic logic [255:0] lanes(input logic [31:0] base, input logic [31:0] step);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = base + step * i;
    return v;
  endfunction

  task automatic mem_wr(input logic [8:0] r, input logic [255:0] d);
    Wen_FIO_MEM = 1'b1; Addr_FIO_MEM = r; Din_FIO_MEM = d;
    @(negedge clk);
    Wen_FIO_MEM = 1'b0;
  endtask

  task automatic tm_push(input logic [9:0] pc, input logic [7:0] mask, input logic [2:0] warp);
    Wen_FIO_TM = 1'b1; Din_FIO_TM = {pc, mask, warp, 8'h00};
    @(negedge clk);
    Wen_FIO_TM = 1'b0;
  endtask

  task automatic read_row(input string nm, input logic [8:0] r);
    Addr_FIO_MEM = r;
    @(negedge clk);
    check(nm, Dout_FIO_MEM, sb_q.pop_front());
  endtask

  // Raise start, wait (bounded) for finished, then clear it
  task automatic run(output int cyc);
    start_FIO_TM = 1'b1;
    cyc = 0;
    while (finished_TM_FIO !== 1'b1 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    check("run_finished", {255'd0, finished_TM_FIO}, 256'd1);
    start_FIO_TM = 1'b0;
    clear_FIO_TM = 1'b1;
    @(negedge clk);
    clear_FIO_TM = 1'b0;
    check("clear_finished", {255'd0, finished_TM_FIO}, 256'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int c100, c10, c300, cyc;
    logic [255:0] p, e;

    mvec[0] = '{9'd5,   lanes(32'd1, 32'd1)};
    mvec[1] = '{9'd300, lanes(32'hDEAD0000, 32'h11)};
    mvec[2] = '{9'd511, lanes(32'hFFFFFFFF, 32'hFFFFFFFF)};
    mvec[3] = '{9'd63,  lanes(32'h12345678, 32'h01010101)};

    prog[0]  = '{10'd0,  ins(4'h6, 3'd1, 3'd0, 3'd0, 16'd0)};
    prog[1]  = '{10'd1,  ins(4'h5, 3'd0, 3'd0, 3'd1, 16'd3)};
    prog[2]  = '{10'd2,  ins(4'hF, 3'd0, 3'd0, 3'd0, 16'd0)};
    prog[3]  = '{10'd16, ins(4'h1, 3'd1, 3'd0, 3'd0, 16'd5)};
    prog[4]  = '{10'd17, ins(4'h1, 3'd2, 3'd0, 3'd0, 16'd7)};
    prog[5]  = '{10'd18, ins(4'h3, 3'd3, 3'd1, 3'd2, 16'd0)};
    prog[6]  = '{10'd19, ins(4'h5, 3'd0, 3'd0, 3'd3, 16'd0)};
    prog[7]  = '{10'd20, ins(4'hF, 3'd0, 3'd0, 3'd0, 16'd0)};
    prog[8]  = '{10'd32, ins(4'h1, 3'd2, 3'd0, 3'd0, 16'd4)};
    prog[9]  = '{10'd33, ins(4'h1, 3'd1, 3'd1, 3'd0, 16'd1)};
    prog[10] = '{10'd34, ins(4'h7, 3'd0, 3'd1, 3'd2, 16'hFFFF)};
    prog[11] = '{10'd35, ins(4'h5, 3'd0, 3'd0, 3'd1, 16'd40)};
    prog[12] = '{10'd36, ins(4'hF, 3'd0, 3'd0, 3'd0, 16'd0)};
    prog[13] = '{10'd48, ins(4'h6, 3'd1, 3'd0, 3'd0, 16'd0)};
    prog[14] = '{10'd49, ins(4'h5, 3'd0, 3'd0, 3'd1, 16'd40)};
    prog[15] = '{10'd50, ins(4'hF, 3'd0, 3'd0, 3'd0, 16'd0)};
    prog[16] = '{10'd64, ins(4'h4, 3'd1, 3'd0, 3'd0, 16'd5)};
    prog[17] = '{10'd65, ins(4'h5, 3'd0, 3'd0, 3'd1, 16'd6)};
    prog[18] = '{10'd66, ins(4'hF, 3'd0, 3'd0, 3'd0, 16'd0)};
    prog[19] = '{10'd80, ins(4'h4, 3'd1, 3'd0, 3'd0, 16'd100)};
    prog[20] = '{10'd81, ins(4'hF, 3'd0, 3'd0, 3'd0, 16'd0)};
    prog[21] = '{10'd84, ins(4'h4, 3'd1, 3'd0, 3'd0, 16'd10)};
    prog[22] = '{10'd85, ins(4'hF, 3'd0, 3'd0, 3'd0, 16'd0)};
    prog[23] = '{10'd88, ins(4'h4, 3'd1, 3'd0, 3'd0, 16'd300)};
    prog[24] = '{10'd89, ins(4'hF, 3'd0, 3'd0, 3'd0, 16'd0)};
    prog[25] = '{10'd96, ins(4'h1, 3'd2, 3'd0, 3'd0, 16'd1)};

    p = lanes(32'hA0, 32'd1);
    e = lanes(32'h23, 32'd0);
    e[255:128] = p[255:128];
    wvec[0] = '{10'd0,  8'hFF, 3'd2, 1'b0, 256'd0, 9'd3,  lanes(32'd16, 32'd1)};
    wvec[1] = '{10'd16, 8'hFF, 3'd0, 1'b0, 256'd0, 9'd0,  lanes(32'h23, 32'd0)};
    wvec[2] = '{10'd16, 8'h0F, 3'd0, 1'b1, p,      9'd0,  e};
    wvec[3] = '{10'd32, 8'hFF, 3'd0, 1'b0, 256'd0, 9'd40, lanes(32'd4, 32'd0)};
    wvec[4] = '{10'd64, 8'hFF, 3'd5, 1'b0, 256'd0, 9'd6,  lanes(32'd1, 32'd1)};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_finished", {255'd0, finished_TM_FIO}, 256'd0);
    check("rst_dout_mem", Dout_FIO_MEM, 256'd0);
    check("rst_dout_ic", {224'd0, Dout_FIO_ICache}, 256'd0);
    rst = 1'b1;
    @(negedge clk);

    // FIO memory write then read back through the scoreboard
    for (int i = 0; i < 4; i++) mem_wr(mvec[i].row, mvec[i].data);
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(mvec[i].data);
      read_row("fio_mem_rd", mvec[i].row);
    end

    // Program load, CLE setup, instruction read back
    for (int i = 0; i < 26; i++) begin
      Wen_FIO_ICache = 1'b1; Addr_FIO_ICache = prog[i].addr; Din_FIO_ICache = prog[i].instr;
      @(negedge clk);
    end
    Wen_FIO_ICache = 1'b0;
    Wen_FIO_ICache = 1'b1; Addr_FIO_ICache = 10'd97; Din_FIO_ICache = ins(4'h7, 3'd0, 3'd0, 3'd2, 16'd0);
    @(negedge clk);
    Wen_FIO_ICache = 1'b0;
    Wen_FIO_CLE = 1'b1; Addr_FIO_CLE = 8'd100; Din_FIO_CLE = 5'd10;
    @(negedge clk);
    Wen_FIO_CLE = 1'b0;
    for (int i = 0; i < 26; i += 5) begin
      Addr_FIO_ICache = prog[i].addr;
      @(negedge clk);
      check("fio_ic_rd", {224'd0, Dout_FIO_ICache}, {224'd0, prog[i].instr});
    end

    // Warp vectors: expected row pushed at launch, compared after finish
    for (int i = 0; i < 5; i++) begin
      if (wvec[i].pre) mem_wr(wvec[i].row, wvec[i].pre_d);
      tm_push(wvec[i].pc, wvec[i].mask, wvec[i].warp);
      sb_q.push_back(wvec[i].exp);
      run(cyc);
      read_row("warp_row", wvec[i].row);
    end

    // CLE miss latency versus cached and shared rows
    tm_push(10'd80, 8'hFF, 3'd0); run(c100);
    tm_push(10'd84, 8'hFF, 3'd0); run(c10);
    tm_push(10'd88, 8'hFF, 3'd0); run(c300);
    check("cle_delta", 256'(c100 - c10), 256'd10);
    check("shared_lat", 256'(c300), 256'(c10));

    // Two descriptors run in FIFO order: TID warp 1 overwrites the loop result
    tm_push(10'd32, 8'hFF, 3'd0);
    tm_push(10'd48, 8'hFF, 3'd1);
    sb_q.push_back(lanes(32'd8, 32'd1));
    run(cyc);
    read_row("fifo_order", 9'd40);

    // Full FIFO: ninth push is dropped, so row 40 keeps the loop result
    for (int i = 0; i < 8; i++) tm_push(10'd32, 8'hFF, 3'd0);
    tm_push(10'd48, 8'hFF, 3'd1);
    sb_q.push_back(lanes(32'd4, 32'd0));
    run(cyc);
    read_row("fifo_full_drop", 9'd40);

    // Reset in the middle of an endless warp
    Addr_FIO_MEM = 9'd5;
    tm_push(10'd96, 8'hFF, 3'd0);
    start_FIO_TM = 1'b1;
    repeat (20) @(negedge clk);
    check("busy_not_finished", {255'd0, finished_TM_FIO}, 256'd0);
    check("busy_dout_mem", Dout_FIO_MEM, lanes(32'd1, 32'd1));
    rst = 1'b0;
    #1;
    check("midrst_finished", {255'd0, finished_TM_FIO}, 256'd0);
    check("midrst_dout_mem", Dout_FIO_MEM, 256'd0);
    start_FIO_TM = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start_FIO_TM = 1'b1;
    cyc = 0;
    while (finished_TM_FIO !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("post_rst_idle", {255'd0, finished_TM_FIO}, 256'd1);
    start_FIO_TM = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
